// File: rtl/fetch_pkg.sv
// Shared state encoding and widths for the fetch_ctrl instruction-fetch sequencer.
package fetch_pkg;

  localparam int AW_DEF = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    REDIRECT,
    STALL,
    HALT
  } state_e;

endpackage

// File: rtl/fetch_ctrl_cnt.sv
// Generic up-counter with synchronous clear and enable; wraps by default, saturates at all-ones when SAT=1.
module fetch_ctrl_cnt
  import fetch_pkg::*;
#(
  parameter int W   = CNT_W,
  parameter bit SAT = 1'b0
) (
  input  logic         clock_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !(SAT && (&cnt_q))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch front-end sequencer: drives pc start/branch, holds on stalls, flushes IF/ID after redirects.
// Optional BRANCH_STATS_EN adds saturating br_cnt_o and stall_cyc_o statistics outputs.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int FLUSH_CYC = 1,
  parameter int STALL_MAX = 15
) (
  input  logic             clock_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  logic [AW-1:0]    startadd_i,
  input  logic             halt_i,
  input  logic             stall_i,
  input  logic             br_req_i,
  input  logic             br_dir_i,
  input  logic [AW-1:0]    br_off_i,
  output logic             start_o,
  output logic [AW-1:0]    startadd_o,
  output logic             branchb_o,
  output logic             branchf_o,
  output logic [AW-1:0]    target_o,
  output logic             pc_hold_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic             busy_o,
  output logic             err_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] stall_cyc_o
`endif
);

  localparam logic [1:0] FLUSH_LIM = 2'(FLUSH_CYC);
  localparam logic [3:0] STALL_LIM = 4'(STALL_MAX - 1);

  state_e        state_d, state_q;
  logic          halt_lat_d, halt_lat_q;
  logic          run_prev_d, run_prev_q;
  logic          err_d, err_q;
  logic          start_d, start_q;
  logic          branchb_d, branchb_q, branchf_d, branchf_q;
  logic          pc_hold_d, pc_hold_q, ifid_stall_d, ifid_stall_q;
  logic          ifid_flush_d, ifid_flush_q, busy_d, busy_q;
  logic [AW-1:0] startadd_d, startadd_q, target_d, target_q;
  logic          enter_redir;
  logic [1:0]    flush_cnt;
  logic [3:0]    stall_cnt;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE:  if (run_i) state_d = START;
      START: state_d = RUN;
      RUN: begin
        if (halt_i)        state_d = HALT;
        else if (br_req_i) state_d = REDIRECT;
        else if (stall_i)  state_d = STALL;
      end
      REDIRECT: begin
        // A halt seen anywhere inside the redirect window is honoured at its end.
        if (flush_cnt == FLUSH_LIM) state_d = (halt_lat_q || halt_i) ? HALT : RUN;
      end
      STALL: begin
        if (br_req_i)       state_d = REDIRECT;
        else if (!stall_i)  state_d = RUN;
        else if (stall_cnt == STALL_LIM) begin
          state_d = HALT;
          err_d   = 1'b1;
        end
      end
      HALT:    if (run_i && !run_prev_q) state_d = START;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    enter_redir  = (state_d == REDIRECT) && (state_q != REDIRECT);
    halt_lat_d   = (state_d == REDIRECT) && (state_q == REDIRECT) && (halt_lat_q || halt_i);
    run_prev_d   = run_i;
    start_d      = (state_d == START);
    startadd_d   = start_d ? startadd_i : startadd_q;
    branchb_d    = enter_redir && br_dir_i;
    branchf_d    = enter_redir && !br_dir_i;
    target_d     = enter_redir ? br_off_i : target_q;
    pc_hold_d    = state_d inside {IDLE, STALL, HALT};
    ifid_stall_d = (state_d == STALL);
    ifid_flush_d = (state_d == REDIRECT) || ((state_d == HALT) && (state_q != HALT));
    busy_d       = !(state_d inside {IDLE, HALT});
  end

  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      halt_lat_q   <= 1'b0;
      run_prev_q   <= 1'b0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      startadd_q   <= '0;
      branchb_q    <= 1'b0;
      branchf_q    <= 1'b0;
      target_q     <= '0;
      pc_hold_q    <= 1'b0;
      ifid_stall_q <= 1'b0;
      ifid_flush_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      halt_lat_q   <= halt_lat_d;
      run_prev_q   <= run_prev_d;
      err_q        <= err_d;
      start_q      <= start_d;
      startadd_q   <= startadd_d;
      branchb_q    <= branchb_d;
      branchf_q    <= branchf_d;
      target_q     <= target_d;
      pc_hold_q    <= pc_hold_d;
      ifid_stall_q <= ifid_stall_d;
      ifid_flush_q <= ifid_flush_d;
      busy_q       <= busy_d;
    end
  end

  fetch_ctrl_cnt #(.W(CNT_W), .SAT(1'b0)) u_fetch_cnt (
    .clock_i(clock_i), .rst_n_i(rst_n_i),
    .clr_i(state_d == START), .en_i(state_d == RUN), .cnt_o(fetch_cnt_o)
  );

  fetch_ctrl_cnt #(.W(2), .SAT(1'b0)) u_flush_cnt (
    .clock_i(clock_i), .rst_n_i(rst_n_i),
    .clr_i(state_d != REDIRECT), .en_i(state_d == REDIRECT), .cnt_o(flush_cnt)
  );

  fetch_ctrl_cnt #(.W(4), .SAT(1'b0)) u_stall_cnt (
    .clock_i(clock_i), .rst_n_i(rst_n_i),
    .clr_i(state_d != STALL), .en_i(state_d == STALL), .cnt_o(stall_cnt)
  );

`ifdef BRANCH_STATS_EN
  fetch_ctrl_cnt #(.W(CNT_W), .SAT(1'b1)) u_br_cnt (
    .clock_i(clock_i), .rst_n_i(rst_n_i),
    .clr_i(start_d), .en_i(enter_redir), .cnt_o(br_cnt_o)
  );

  fetch_ctrl_cnt #(.W(CNT_W), .SAT(1'b1)) u_stall_cyc (
    .clock_i(clock_i), .rst_n_i(rst_n_i),
    .clr_i(1'b0), .en_i(state_d == STALL), .cnt_o(stall_cyc_o)
  );
`endif

  assign start_o      = start_q;
  assign startadd_o   = startadd_q;
  assign branchb_o    = branchb_q;
  assign branchf_o    = branchf_q;
  assign target_o     = target_q;
  assign pc_hold_o    = pc_hold_q;
  assign ifid_stall_o = ifid_stall_q;
  assign ifid_flush_o = ifid_flush_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed vector table, multi-cycle corner sequences, randomized run vs reference model.
module tb_fetch_ctrl;

  localparam int AW        = 8;
  localparam int FLUSH_CYC = 2;
  localparam int STALL_MAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          run = 1'b0, halt = 1'b0, stall = 1'b0, br_req = 1'b0, br_dir = 1'b0;
  logic [AW-1:0] startadd = '0, br_off = '0;
  logic          start_o, branchb_o, branchf_o, pc_hold_o, ifid_stall_o, ifid_flush_o, busy_o, err_o;
  logic [AW-1:0] startadd_o, target_o;
  logic [15:0]   fetch_cnt_o;

  fetch_ctrl #(.AW(AW), .FLUSH_CYC(FLUSH_CYC), .STALL_MAX(STALL_MAX)) dut (
    .clock_i(clk), .rst_n_i(rst_n), .run_i(run), .startadd_i(startadd), .halt_i(halt),
    .stall_i(stall), .br_req_i(br_req), .br_dir_i(br_dir), .br_off_i(br_off),
    .start_o(start_o), .startadd_o(startadd_o), .branchb_o(branchb_o), .branchf_o(branchf_o),
    .target_o(target_o), .pc_hold_o(pc_hold_o), .ifid_stall_o(ifid_stall_o),
    .ifid_flush_o(ifid_flush_o), .fetch_cnt_o(fetch_cnt_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the sequencer's mode from the behavioural rules.
  localparam int M_IDLE = 0, M_START = 1, M_RUN = 2, M_RED = 3, M_STL = 4, M_HALT = 5;
  int          m_mode, flush_left, stall_len;
  bit          halt_pend, run_prev;
  bit          e_start, e_hold, e_istall, e_flush, e_bb, e_bf, e_busy, e_err;
  logic [7:0]  e_sa, e_tgt;
  logic [15:0] e_cnt;

  task automatic model_reset();
    m_mode = M_IDLE; flush_left = 0; stall_len = 0; halt_pend = 0; run_prev = 0;
    e_start = 0; e_hold = 0; e_istall = 0; e_flush = 0; e_bb = 0; e_bf = 0;
    e_busy = 0; e_err = 0; e_sa = '0; e_tgt = '0; e_cnt = '0;
  endtask

  task automatic model_step();
    int nm;
    bit new_br;
    nm = m_mode;
    new_br = 0;
    case (m_mode)
      M_IDLE:  if (run) nm = M_START;
      M_START: nm = M_RUN;
      M_RUN: begin
        if (halt) nm = M_HALT;
        else if (br_req) begin nm = M_RED; new_br = 1; end
        else if (stall) begin nm = M_STL; stall_len = 1; end
      end
      M_RED: begin
        halt_pend = halt_pend | halt;
        if (flush_left == 0) nm = halt_pend ? M_HALT : M_RUN;
        else flush_left--;
      end
      M_STL: begin
        if (br_req) begin nm = M_RED; new_br = 1; end
        else if (!stall) nm = M_RUN;
        else if (stall_len + 1 >= STALL_MAX) begin nm = M_HALT; e_err = 1; end
        else stall_len++;
      end
      M_HALT: if (run && !run_prev) nm = M_START;
      default: ;
    endcase
    if (new_br) begin
      halt_pend = 0;
      flush_left = FLUSH_CYC - 1;
      e_tgt = br_off;
    end
    e_bb = new_br && br_dir;
    e_bf = new_br && !br_dir;
    e_start = (nm == M_START);
    if (e_start) begin e_sa = startadd; e_cnt = '0; end
    if (nm == M_RUN) e_cnt = e_cnt + 16'd1;
    e_hold   = (nm == M_IDLE) || (nm == M_STL) || (nm == M_HALT);
    e_istall = (nm == M_STL);
    e_flush  = (nm == M_RED) || (nm == M_HALT && m_mode != M_HALT);
    e_busy   = !(nm == M_IDLE || nm == M_HALT);
    run_prev = run;
    m_mode = nm;
  endtask

  task automatic check_model();
    chk("start_o", 32'(start_o), 32'(e_start));
    chk("startadd_o", 32'(startadd_o), 32'(e_sa));
    chk("branchb_o", 32'(branchb_o), 32'(e_bb));
    chk("branchf_o", 32'(branchf_o), 32'(e_bf));
    chk("target_o", 32'(target_o), 32'(e_tgt));
    chk("pc_hold_o", 32'(pc_hold_o), 32'(e_hold));
    chk("ifid_stall_o", 32'(ifid_stall_o), 32'(e_istall));
    chk("ifid_flush_o", 32'(ifid_flush_o), 32'(e_flush));
    chk("fetch_cnt_o", 32'(fetch_cnt_o), 32'(e_cnt));
    chk("busy_o", 32'(busy_o), 32'(e_busy));
    chk("err_o", 32'(err_o), 32'(e_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_in(input bit r, input bit h, input bit s, input bit b, input bit d);
    run = r; halt = h; stall = s; br_req = b; br_dir = d;
  endtask

  typedef struct packed {
    logic        run;
    logic [7:0]  sa;
    logic        halt, stall, br, dir;
    logic [7:0]  off;
    logic        start, hold, istall, flush, bb, bf, busy;
    logic [15:0] cnt;
    logic [7:0]  sae, tgt;
  } vec_t;

  function automatic vec_t mk(input int r, input int sa, input int h, input int s, input int b,
                              input int d, input int off, input int st, input int hold,
                              input int ist, input int fl, input int bb, input int bf,
                              input int busy, input int cnt, input int sae, input int tgt);
    vec_t v;
    v.run = r[0]; v.sa = sa[7:0]; v.halt = h[0]; v.stall = s[0]; v.br = b[0]; v.dir = d[0];
    v.off = off[7:0]; v.start = st[0]; v.hold = hold[0]; v.istall = ist[0]; v.flush = fl[0];
    v.bb = bb[0]; v.bf = bf[0]; v.busy = busy[0]; v.cnt = cnt[15:0]; v.sae = sae[7:0];
    v.tgt = tgt[7:0];
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    //          run sa    h s b d off   st hd is fl bb bf by cnt sae   tgt
    tbl[0]  = mk(1, 'h10, 0,0,0,0,0,    1, 0, 0, 0, 0, 0, 1, 0, 'h10, 0);
    tbl[1]  = mk(1, 'h10, 0,0,0,0,0,    0, 0, 0, 0, 0, 0, 1, 1, 'h10, 0);
    tbl[2]  = mk(0, 0,    0,0,0,0,0,    0, 0, 0, 0, 0, 0, 1, 2, 'h10, 0);
    tbl[3]  = mk(0, 0,    0,0,0,0,0,    0, 0, 0, 0, 0, 0, 1, 3, 'h10, 0);
    tbl[4]  = mk(0, 0,    0,0,0,0,0,    0, 0, 0, 0, 0, 0, 1, 4, 'h10, 0);
    tbl[5]  = mk(0, 0,    0,0,0,0,0,    0, 0, 0, 0, 0, 0, 1, 5, 'h10, 0);
    tbl[6]  = mk(0, 0,    0,0,1,1,'h04, 0, 0, 0, 1, 1, 0, 1, 5, 'h10, 'h04);
    tbl[7]  = mk(0, 0,    0,0,1,0,'h33, 0, 0, 0, 1, 0, 0, 1, 5, 'h10, 'h04);
    tbl[8]  = mk(0, 0,    0,0,0,0,0,    0, 0, 0, 0, 0, 0, 1, 6, 'h10, 'h04);
    tbl[9]  = mk(0, 0,    0,1,0,0,0,    0, 1, 1, 0, 0, 0, 1, 6, 'h10, 'h04);
    tbl[10] = mk(0, 0,    0,1,0,0,0,    0, 1, 1, 0, 0, 0, 1, 6, 'h10, 'h04);
    tbl[11] = mk(0, 0,    0,1,0,0,0,    0, 1, 1, 0, 0, 0, 1, 6, 'h10, 'h04);
    tbl[12] = mk(0, 0,    0,0,0,0,0,    0, 0, 0, 0, 0, 0, 1, 7, 'h10, 'h04);
    tbl[13] = mk(0, 0,    1,1,1,1,'h55, 0, 1, 0, 1, 0, 0, 0, 7, 'h10, 'h04);
    tbl[14] = mk(0, 0,    0,0,0,0,0,    0, 1, 0, 0, 0, 0, 0, 7, 'h10, 'h04);
    tbl[15] = mk(1, 'h20, 0,0,0,0,0,    1, 0, 0, 0, 0, 0, 1, 0, 'h20, 'h04);
    tbl[16] = mk(1, 0,    0,0,0,0,0,    0, 0, 0, 0, 0, 0, 1, 1, 'h20, 'h04);

    model_reset();
    #1 rst_n = 1'b0;
    #11;
    check_model();
    chk("reset_busy", 32'(busy_o), 32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run = tbl[i].run; startadd = tbl[i].sa; halt = tbl[i].halt; stall = tbl[i].stall;
      br_req = tbl[i].br; br_dir = tbl[i].dir; br_off = tbl[i].off;
      tick();
      chk($sformatf("v%0d_start", i), 32'(start_o), 32'(tbl[i].start));
      chk($sformatf("v%0d_hold", i), 32'(pc_hold_o), 32'(tbl[i].hold));
      chk($sformatf("v%0d_istall", i), 32'(ifid_stall_o), 32'(tbl[i].istall));
      chk($sformatf("v%0d_flush", i), 32'(ifid_flush_o), 32'(tbl[i].flush));
      chk($sformatf("v%0d_bb", i), 32'(branchb_o), 32'(tbl[i].bb));
      chk($sformatf("v%0d_bf", i), 32'(branchf_o), 32'(tbl[i].bf));
      chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(tbl[i].busy));
      chk($sformatf("v%0d_cnt", i), 32'(fetch_cnt_o), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_sa", i), 32'(startadd_o), 32'(tbl[i].sae));
      chk($sformatf("v%0d_tgt", i), 32'(target_o), 32'(tbl[i].tgt));
    end

    // Watchdog: 15 consecutive stall samples trip err_o and force HALT.
    set_in(0, 0, 1, 0, 0);
    for (int i = 0; i < 14; i++) tick();
    chk("wd_no_err_yet", 32'(err_o), 32'(0));
    chk("wd_still_stall", 32'(ifid_stall_o), 32'(1));
    tick();
    chk("wd_err", 32'(err_o), 32'(1));
    chk("wd_halt_busy", 32'(busy_o), 32'(0));
    chk("wd_halt_hold", 32'(pc_hold_o), 32'(1));
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("wd_err_sticky", 32'(err_o), 32'(1));

    // Branch during STALL (forward), then a second request inside REDIRECT is ignored.
    set_in(1, 0, 0, 0, 0); tick();
    chk("restart_start", 32'(start_o), 32'(1));
    tick();
    set_in(1, 0, 1, 0, 0); tick(); tick();
    br_off = 8'h9a;
    set_in(1, 0, 1, 1, 0); tick();
    chk("stl_br_bf", 32'(branchf_o), 32'(1));
    chk("stl_br_bb", 32'(branchb_o), 32'(0));
    chk("stl_br_istall", 32'(ifid_stall_o), 32'(0));
    chk("stl_br_tgt", 32'(target_o), 32'(8'h9a));
    br_off = 8'h11;
    set_in(1, 0, 0, 1, 1); tick();
    chk("red_rebr_bb", 32'(branchb_o), 32'(0));
    chk("red_rebr_bf", 32'(branchf_o), 32'(0));
    chk("red_rebr_flush", 32'(ifid_flush_o), 32'(1));
    set_in(1, 0, 0, 0, 0); tick();
    chk("red_exit_run", 32'(busy_o & ~ifid_flush_o), 32'(1));

    // Halt seen mid-REDIRECT is latched and taken when the flush window ends.
    set_in(1, 0, 0, 1, 1); tick();
    set_in(1, 1, 0, 0, 0); tick();
    set_in(1, 0, 0, 0, 0); tick();
    chk("red_halt_busy", 32'(busy_o), 32'(0));
    chk("red_halt_flush", 32'(ifid_flush_o), 32'(1));

    // Asynchronous reset in the middle of RUN.
    set_in(0, 0, 0, 0, 0); tick();
    set_in(1, 0, 0, 0, 0); tick(); tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("arst_cnt", 32'(fetch_cnt_o), 32'(0));
    chk("arst_err", 32'(err_o), 32'(0));
    chk("arst_hold", 32'(pc_hold_o), 32'(0));
    #3 rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      run      = ($urandom_range(0, 2) != 0);
      halt     = ($urandom_range(0, 24) == 0);
      stall    = stall ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      br_req   = ($urandom_range(0, 6) == 0);
      br_dir   = 1'($urandom_range(0, 1));
      br_off   = 8'($urandom);
      startadd = 8'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
